soc_bus_bridge: RTL

Single-master bus bridge between the RV32 core's native memory interface and the four SoC slaves (memory, GPIO, UART, I2C). Consumes the one-hot region selects from the SoC address decoder and registers each request. It forwards the request to exactly one slave, then returns that slave's read data and ready to the core. Unmapped addresses and slaves that never answer are terminated with an error response, so the core never hangs.

---
 rtl/soc_bus_pkg.sv | 30 +++
 rtl/bus_timeout_counter.sv | 38 +++
 rtl/soc_bus_bridge.sv | 116 +++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the core-to-SoC bus bridge: slave indices, FSM states
// and the select priority encoder.
package soc_bus_pkg;

  localparam int unsigned SLV_MEM  = 0;
  localparam int unsigned SLV_GPIO = 1;
  localparam int unsigned SLV_UART = 2;
  localparam int unsigned SLV_I2C  = 3;
  localparam int unsigned NUM_SLV  = 4;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StErr
  } bus_state_e;

  typedef logic [1:0] slv_idx_t;

  // Lowest slave index wins when the decoder raises more than one select.
  function automatic slv_idx_t sel_to_idx(input logic [NUM_SLV-1:0] sel);
    if (sel[SLV_MEM])       return slv_idx_t'(SLV_MEM);
    else if (sel[SLV_GPIO]) return slv_idx_t'(SLV_GPIO);
    else if (sel[SLV_UART]) return slv_idx_t'(SLV_UART);
    else                    return slv_idx_t'(SLV_I2C);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter that flags when a slave has been waited on for
// TIMEOUT_CYCLES cycles.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TermCnt);

  // Holds at the terminal count instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_bus_bridge.sv
// Single-master bridge from the core memory port to four SoC slaves; unmapped
// or unresponsive accesses complete with an error response.
module soc_bus_bridge
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_valid,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_wstrb,
  output logic                   cpu_ready,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_err,
  input  logic                   sel_mem,
  input  logic                   sel_gpio,
  input  logic                   sel_uart,
  input  logic                   sel_i2c,
  output logic [NUM_SLV-1:0]     slv_valid,
  output logic [31:0]            slv_addr,
  output logic [31:0]            slv_wdata,
  output logic [3:0]             slv_wstrb,
  input  logic [NUM_SLV-1:0]     slv_ready,
  input  logic [32*NUM_SLV-1:0]  slv_rdata
);

  localparam logic [NUM_SLV-1:0] OneHot0 = NUM_SLV'(1);

  bus_state_e         state_q;
  slv_idx_t           idx_q;
  slv_idx_t           req_idx;
  logic [NUM_SLV-1:0] sel_vec;
  logic [31:0]        sel_rdata;
  logic               timeout;

  always_comb begin
    sel_vec            = '0;
    sel_vec[SLV_MEM]   = sel_mem;
    sel_vec[SLV_GPIO]  = sel_gpio;
    sel_vec[SLV_UART]  = sel_uart;
    sel_vec[SLV_I2C]   = sel_i2c;
    req_idx            = sel_to_idx(sel_vec);
    sel_rdata          = slv_rdata[{idx_q, 5'd0} +: 32];
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (state_q == StIdle),
    .en_i    (state_q == StBusy),
    .tc_o    (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      slv_valid <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_valid) begin
            if (|sel_vec) begin
              idx_q     <= req_idx;
              slv_addr  <= cpu_addr;
              slv_wdata <= cpu_wdata;
              slv_wstrb <= cpu_wstrb;
              slv_valid <= OneHot0 << req_idx;
              state_q   <= StBusy;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= ERR_RDATA;
              state_q   <= StErr;
            end
          end
        end
        // A ready in the terminal cycle takes precedence over the timeout.
        StBusy: begin
          if (slv_ready[idx_q]) begin
            slv_valid <= '0;
            cpu_rdata <= sel_rdata;
            cpu_ready <= 1'b1;
            state_q   <= StResp;
          end else if (timeout) begin
            slv_valid <= '0;
            cpu_rdata <= ERR_RDATA;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            state_q   <= StErr;
          end
        end
        StResp, StErr: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
